// File: rtl/pll_lock_sequencer_if.sv
// Status/control bundle between the board-side controller and the PLL lock sequencer.
// The sequencer takes the slave view; the supervising side (board logic or bench) takes master.
interface pll_lock_sequencer_if;
  logic       pll_lock_i;
  logic       sw_req;
  logic       pll_reset;
  logic       sys_resetn_o;
  logic       pll_ok;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lol_cnt;

  modport master (
    output pll_lock_i, sw_req,
    input  pll_reset, sys_resetn_o, pll_ok, fail, retry_cnt, lol_cnt
  );

  modport slave (
    input  pll_lock_i, sw_req,
    output pll_reset, sys_resetn_o, pll_ok, fail, retry_cnt, lol_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset pulse, bounded lock wait, lock stability check, bounded retry,
// then core reset release from qualified lock. Runs in the PLL reference clock domain.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYC = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int LOCK_STABLE   = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  pll_lock_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {PRST, WLOCK, STAB, RUN, FAIL} state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_q, retry_nxt;
  logic [7:0]       lol_q, lol_nxt;
  logic             fail_attempt;
  logic             sync1, lock_s;
  logic             pll_reset_q, sys_resetn_q, pll_ok_q, fail_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock_i;
      lock_s <= sync1;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    retry_nxt    = retry_q;
    lol_nxt      = lol_q;
    fail_attempt = 1'b0;

    unique case (state)
      PRST: begin
        if (cnt == RST_LAST) begin
          state_nxt = WLOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WLOCK: begin
        if (lock_s) begin
          state_nxt = STAB;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          fail_attempt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STAB: begin
        if (!lock_s) begin
          fail_attempt = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        // Loss of lock takes priority over a coincident software restart.
        if (!lock_s) begin
          state_nxt = PRST;
          cnt_nxt   = '0;
          retry_nxt = '0;
          if (lol_q != 8'hFF) lol_nxt = lol_q + 8'd1;
        end else if (bus.sw_req) begin
          state_nxt = PRST;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      FAIL: begin
        if (bus.sw_req) begin
          state_nxt = PRST;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = PRST;
        cnt_nxt   = '0;
      end
    endcase

    if (fail_attempt) begin
      retry_nxt = retry_q + 4'd1;
      cnt_nxt   = '0;
      state_nxt = (retry_nxt == RETRY_LIMIT) ? FAIL : PRST;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= PRST;
      cnt          <= '0;
      retry_q      <= '0;
      lol_q        <= '0;
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      pll_ok_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry_q      <= retry_nxt;
      lol_q        <= lol_nxt;
      // Outputs decode the next state so they switch on the same edge as the state.
      pll_reset_q  <= (state_nxt == PRST) || (state_nxt == FAIL);
      sys_resetn_q <= (state_nxt == RUN);
      pll_ok_q     <= (state_nxt == RUN);
      fail_q       <= (state_nxt == FAIL);
    end
  end

  assign bus.pll_reset    = pll_reset_q;
  assign bus.sys_resetn_o = sys_resetn_q;
  assign bus.pll_ok       = pll_ok_q;
  assign bus.fail         = fail_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.lol_cnt      = lol_q;

endmodule
